biriscv_trace_fifo: RTL and testbench

- Retire-trace collector that feeds the per-instruction trace/disassembly monitor.
- Captures up to two retired instructions per cycle from the dual-issue writeback stage (slot 0 older than slot 1) into a FIFO.
- Replays them as a single in-order valid/pc/opcode stream, one instruction per accepted cycle.
- Retirement is never stalled. On overflow, entries are dropped (youngest first), counted and flagged.

---
 rtl/biriscv_trace_fifo_if.sv | 28 ++
 rtl/biriscv_trace_fifo.sv | 117 +++++++++++
 tb/tb_biriscv_trace_fifo.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_trace_fifo_if.sv
// Retire-trace bus: dual retire capture side plus the replayed
// single-instruction valid/ready output stream.
interface biriscv_trace_fifo_if;
  logic        ret0_valid;
  logic [31:0] ret0_pc;
  logic [31:0] ret0_opcode;
  logic        ret1_valid;
  logic [31:0] ret1_pc;
  logic [31:0] ret1_opcode;
  logic        ready;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] opcode;

  modport master (
    output ret0_valid, ret0_pc, ret0_opcode,
    output ret1_valid, ret1_pc, ret1_opcode,
    output ready,
    input  valid, pc, opcode
  );

  modport slave (
    input  ret0_valid, ret0_pc, ret0_opcode,
    input  ret1_valid, ret1_pc, ret1_opcode,
    input  ready,
    output valid, pc, opcode
  );
endinterface

// File: rtl/biriscv_trace_fifo.sv
// Retire-trace collector: compacts up to two retirements per cycle
// into a FIFO and replays them in order; never stalls retirement.
module biriscv_trace_fifo #(
  parameter int DEPTH_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               clr_i,
  biriscv_trace_fifo_if.slave trc,
  output logic [DEPTH_W:0]   level_o,
  output logic               overflow_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W+1)'(DEPTH);

  logic [63:0]        mem_q [DEPTH];
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] wr_ptr1;
  logic [DEPTH_W:0]   level_q, level_d;
  logic [DEPTH_W:0]   free;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         n_cand, n_push, n_drop;
  logic [CNT_W:0]     drop_sum;
  logic               pop, we0, we1;
  logic [63:0]        wdata0, wdata1;
  logic [63:0]        head;

  always_comb begin
    n_cand = 2'd0;
    if (enable_i)
      n_cand = {1'b0, trc.ret0_valid} + {1'b0, trc.ret1_valid};
    // Space is judged on the start-of-cycle level; a pop never frees a slot
    free = DEPTH_L - level_q;
    if (free >= {{(DEPTH_W-1){1'b0}}, n_cand})
      n_push = n_cand;
    else
      n_push = free[1:0];
    n_drop = n_cand - n_push;

    wdata0 = trc.ret0_valid ? {trc.ret0_pc, trc.ret0_opcode}
                            : {trc.ret1_pc, trc.ret1_opcode};
    wdata1 = {trc.ret1_pc, trc.ret1_opcode};
    wr_ptr1 = wr_ptr_q + 1'b1;
    we0 = !clr_i && (n_push != 2'd0);
    we1 = !clr_i && (n_push == 2'd2);

    pop = (level_q != '0) && trc.ready;
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(n_drop);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;

    unique case (1'b1)
      clr_i: begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        level_d  = '0;
        drop_d   = '0;
        ovf_d    = 1'b0;
      end
      default: begin
        rd_ptr_d = rd_ptr_q + DEPTH_W'(pop);
        wr_ptr_d = wr_ptr_q + DEPTH_W'(n_push);
        level_d  = level_q + (DEPTH_W+1)'(n_push)
                           - (DEPTH_W+1)'(pop);
        if (n_drop != 2'd0) begin
          ovf_d  = 1'b1;
          drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked while empty
  always_ff @(posedge clk_i) begin
    if (we0) mem_q[wr_ptr_q] <= wdata0;
    if (we1) mem_q[wr_ptr1]  <= wdata1;
  end

  always_comb begin
    head = '0;
    if (level_q != '0) head = mem_q[rd_ptr_q];
  end

  assign trc.valid  = (level_q != '0);
  assign trc.pc     = head[63:32];
  assign trc.opcode = head[31:0];
  assign level_o    = level_q;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_biriscv_trace_fifo.sv
// Directed plus randomized bench for biriscv_trace_fifo,
// checked against a queue-based reference model.
module tb_biriscv_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clr;
  logic [4:0]  level;
  logic        ovf;
  logic [15:0] drop;

  biriscv_trace_fifo_if bus ();

  biriscv_trace_fifo #(.DEPTH_W(4), .CNT_W(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .clr_i      (clr),
    .trc        (bus.slave),
    .level_o    (level),
    .overflow_o (ovf),
    .drop_cnt_o (drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q[$];
  int          mdrop;
  bit          movf;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] h;
    h = (q.size() != 0) ? q[0] : 64'd0;
    chk("valid", 64'(bus.valid), 64'(q.size() != 0));
    chk("pc", 64'(bus.pc), 64'(h[63:32]));
    chk("opcode", 64'(bus.opcode), 64'(h[31:0]));
    chk("level", 64'(level), 64'(q.size()));
    chk("overflow", 64'(ovf), 64'(movf));
    chk("drop_cnt", 64'(drop), 64'(mdrop));
  endtask

  // Reference: queue of retired instructions; space judged before pop
  task automatic model_step();
    int free;
    if (clr) begin
      q.delete();
      mdrop = 0;
      movf  = 1'b0;
    end else begin
      free = DEPTH - q.size();
      if (bus.ready && q.size() != 0) void'(q.pop_front());
      if (enable && bus.ret0_valid) begin
        if (free > 0) begin
          q.push_back({bus.ret0_pc, bus.ret0_opcode});
          free--;
        end else begin
          movf = 1'b1;
          if (mdrop < 65535) mdrop++;
        end
      end
      if (enable && bus.ret1_valid) begin
        if (free > 0) begin
          q.push_back({bus.ret1_pc, bus.ret1_opcode});
          free--;
        end else begin
          movf = 1'b1;
          if (mdrop < 65535) mdrop++;
        end
      end
    end
  endtask

  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ret(bit v0, logic [31:0] p0, logic [31:0] o0,
                     bit v1, logic [31:0] p1, logic [31:0] o1);
    bus.ret0_valid  = v0;
    bus.ret0_pc     = p0;
    bus.ret0_opcode = o0;
    bus.ret1_valid  = v1;
    bus.ret1_pc     = p1;
    bus.ret1_opcode = o1;
  endtask

  task automatic idle();
    ret(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    clr = 1'b0;
    bus.ready = 1'b0;
    idle();
    mdrop = 0;
    movf = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // single-slot stream
    bus.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ret(1'b1, 32'h8000_0000 + 32'(4 * i), 32'h13, 1'b0, 32'd0, 32'd0);
      cyc();
    end
    idle();
    repeat (3) cyc();

    // dual retire ordering, then slot1-only
    bus.ready = 1'b0;
    ret(1'b1, 32'h100, 32'h0015_0513, 1'b1, 32'h104, 32'h0000_8067);
    cyc();
    idle();
    cyc();
    chk("dual_level", 64'(level), 64'd2);
    bus.ready = 1'b1;
    repeat (3) cyc();
    ret(1'b0, 32'd0, 32'd0, 1'b1, 32'h200, 32'h13);
    cyc();
    idle();
    repeat (3) cyc();

    // fill and overflow
    bus.ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      ret(1'b1, 32'h1000 + 32'(4 * i), 32'($urandom), 1'b0, 32'd0, 32'd0);
      cyc();
    end
    ret(1'b1, 32'h300, 32'h13, 1'b1, 32'h304, 32'h13);
    cyc();
    chk("full_level", 64'(level), 64'd16);
    chk("first_drop", 64'(drop), 64'd1);
    chk("first_ovf", 64'(ovf), 64'd1);
    ret(1'b1, 32'h308, 32'h13, 1'b1, 32'h30c, 32'h13);
    cyc();
    chk("second_drop", 64'(drop), 64'd3);

    // full with simultaneous pop: push still dropped
    bus.ready = 1'b1;
    ret(1'b1, 32'h310, 32'h13, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("pop_full_level", 64'(level), 64'd15);
    chk("pop_full_drop", 64'(drop), 64'd4);
    bus.ready = 1'b0;
    ret(1'b1, 32'h314, 32'h13, 1'b0, 32'd0, 32'd0);
    cyc();
    chk("refill_level", 64'(level), 64'd16);

    // drain to 5, then clear with a same-cycle push
    bus.ready = 1'b1;
    idle();
    repeat (11) cyc();
    bus.ready = 1'b0;
    clr = 1'b1;
    ret(1'b1, 32'h400, 32'h13, 1'b1, 32'h404, 32'h13);
    cyc();
    clr = 1'b0;
    idle();
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_drop", 64'(drop), 64'd0);
    chk("clr_ovf", 64'(ovf), 64'd0);

    // wrap-around with ready toggling
    for (int i = 0; i < 40; i++) begin
      bus.ready = (i % 2 == 1);
      ret(1'b1, 32'h2000 + 32'(4 * i), 32'($urandom), 1'b0, 32'd0, 32'd0);
      cyc();
    end
    bus.ready = 1'b1;
    idle();
    repeat (24) cyc();

    // capture disabled
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ret(1'b1, 32'($urandom), 32'($urandom), 1'b1, 32'($urandom), 32'($urandom));
      cyc();
    end
    enable = 1'b1;
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ret(1'($urandom_range(1)), 32'($urandom), 32'($urandom),
          1'($urandom_range(1)), 32'($urandom), 32'($urandom));
      bus.ready = ($urandom_range(3) != 0);
      enable = ($urandom_range(15) != 0);
      clr = ($urandom_range(60) == 0);
      cyc();
    end
    clr = 1'b0;
    enable = 1'b1;

    // async reset mid-drain
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ret(1'b1, 32'h5000 + 32'(4 * i), 32'h13, 1'b0, 32'd0, 32'd0);
      cyc();
    end
    idle();
    bus.ready = 1'b1;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_pc", 64'(bus.pc), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    q.delete();
    mdrop = 0;
    movf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
